// File: rtl/filter_pkg.sv
// filter_pkg: shared sample widths and round/saturate helpers for the filter chain
package filter_pkg;
    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 16;

    function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input int sh);
        return (sh > 0) ? (v + (64'sd1 <<< (sh - 1))) >>> sh : v;
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) ? hi : (v < lo) ? lo : v;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with level, async active-low reset and sync clear
module sync_fifo
    import filter_pkg::*;
#(
    parameter int WIDTH = DEF_OUT_W,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty   = level_q == '0;
    assign full    = level_q == LW'(DEPTH);
    assign level   = level_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_q[rd_q];

    // next-state: write at wr, advance pointers, track occupancy; clear empties
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d    = clear ? '0 : do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = clear ? '0 : do_pop ? rd_q + 1'b1 : rd_q;
        level_d = clear ? '0 : level_q + LW'(do_push) - LW'(do_pop);
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/filter_decimator.sv
// filter_decimator: boxcar accumulate-and-dump decimator with round/saturate and output FIFO
module filter_decimator
    import filter_pkg::*;
#(
    parameter int IN_W       = DEF_IN_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [LW-1:0]           level,
    output logic                    overflow
);
    localparam int SW = IN_W + $clog2(DECIM);
    localparam int CW = $clog2(DECIM);

    logic signed [SW-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sum_vld_q, sum_vld_d, ovf_q, ovf_d;
    logic [OUT_W-1:0]     res;
    logic                 full, empty;

    assign res       = OUT_W'(sat(round_shr(64'(sum_q), SHIFT), OUT_W));
    assign out_valid = !empty;
    assign overflow  = ovf_q;

    // accumulate DECIM samples, dump the group sum into the stage register, flag drops
    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        sum_vld_d = 1'b0;
        ovf_d     = ovf_q | (sum_vld_q & full & !out_ready);
        if (clear) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (in_valid) begin
            if (cnt_q == CW'(DECIM - 1)) begin
                sum_d     = acc_q + SW'(in_sample);
                sum_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = acc_q + SW'(in_sample);
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    sync_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (sum_vld_q),
        .pop   (out_ready),
        .din   (res),
        .dout  (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule

// File: tb/tb_filter_decimator.sv
// tb_filter_decimator: directed and random checks of two decimator instances (SHIFT=2, SHIFT=0)
module tb_filter_decimator;
    logic               clk, reset, clear, in_valid, out_ready;
    logic signed [15:0] in_sample;
    logic               ov0, ov1, of0, of1;
    logic signed [15:0] od0, od1;
    logic [2:0]         lv0, lv1;

    int total = 0;
    int bad   = 0;

    int grp[$];
    int fsum[$];
    bit pend_v;
    int pend_sum;
    bit ovf;

    filter_decimator u0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sample(in_sample),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .level(lv0), .overflow(of0)
    );

    filter_decimator #(.SHIFT(0)) u1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_sample(in_sample),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .level(lv1), .overflow(of1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_res(int s, int sh);
        int d, n, q;
        d = 1 << sh;
        n = s + ((sh > 0) ? d / 2 : 0);
        q = n / d;
        if (n % d != 0 && n < 0) q--;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        grp.delete();
        fsum.delete();
        pend_v = 0;
        ovf = 0;
    endtask

    task automatic model_step(bit c, bit v, int x, bit r);
        bit pop;
        int s;
        if (c) begin
            model_reset();
            return;
        end
        pop = fsum.size() > 0 && r;
        if (pend_v && fsum.size() == 4 && !pop) ovf = 1;
        if (pop) void'(fsum.pop_front());
        if (pend_v && fsum.size() < 4) fsum.push_back(pend_sum);
        pend_v = 0;
        if (v) begin
            grp.push_back(x);
            if (grp.size() == 4) begin
                s = 0;
                foreach (grp[i]) s += grp[i];
                pend_sum = s;
                pend_v = 1;
                grp.delete();
            end
        end
    endtask

    task automatic check_all();
        int n;
        n = fsum.size();
        chk("valid_s2", ov0, int'(n > 0));
        chk("data_s2", od0, n > 0 ? exp_res(fsum[0], 2) : 0);
        chk("level_s2", lv0, n);
        chk("ovf_s2", of0, int'(ovf));
        chk("valid_s0", ov1, int'(n > 0));
        chk("data_s0", od1, n > 0 ? exp_res(fsum[0], 0) : 0);
        chk("level_s0", lv1, n);
        chk("ovf_s0", of1, int'(ovf));
    endtask

    task automatic cyc(bit c, bit v, int x, bit r);
        clear = c;
        in_valid = v;
        in_sample = 16'(x);
        out_ready = r;
        model_step(c, v, x, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic feed4(int a, int b, int c, int d, bit r);
        cyc(0, 1, a, r);
        cyc(0, 1, b, r);
        cyc(0, 1, c, r);
        cyc(0, 1, d, r);
    endtask

    initial begin
        logic signed [15:0] rs;
        bit c, v, r;
        int x;
        reset = 0; clear = 0; in_valid = 0; in_sample = 0; out_ready = 1;
        model_reset();
        #3;
        check_all();
        @(posedge clk);
        #1;
        reset = 1;

        // 1: ramp averages to 3, visible two edges after the 4th sample
        feed4(1, 2, 3, 4, 1);
        chk("t1_not_yet", ov0, 0);
        cyc(0, 0, 0, 1);
        chk("t1_valid", ov0, 1);
        chk("t1_data", od0, 3);
        cyc(0, 0, 0, 1);
        chk("t1_popped", ov0, 0);

        // 2: negative ramp, then gapped input
        feed4(-1, -2, -3, -4, 1);
        cyc(0, 0, 0, 0);
        chk("t2_neg", od0, -2);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 1, 1); cyc(0, 0, 0, 1);
        cyc(0, 1, 2, 1); cyc(0, 0, 0, 1);
        cyc(0, 1, 3, 1); cyc(0, 0, 0, 1);
        cyc(0, 1, 4, 0); cyc(0, 0, 0, 0);
        chk("t2_gap", od0, 3);
        cyc(0, 0, 0, 1);

        // 3: saturation at both rails
        feed4(32767, 32767, 32767, 32767, 0);
        cyc(0, 0, 0, 0);
        chk("t3_pos_s0", od1, 32767);
        chk("t3_pos_s2", od0, 32767);
        cyc(0, 0, 0, 1);
        feed4(-32768, -32768, -32768, -32768, 0);
        cyc(0, 0, 0, 0);
        chk("t3_neg_s0", od1, -32768);
        chk("t3_neg_s2", od0, -32768);
        cyc(0, 0, 0, 1);

        // 4: full FIFO drops the 5th result, then drains
        for (int i = 0; i < 20; i++) cyc(0, 1, 8, 0);
        cyc(0, 0, 0, 0);
        chk("t4_level", lv0, 4);
        chk("t4_ovf", of0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_head", od0, 8);
            cyc(0, 0, 0, 1);
        end
        chk("t4_empty", ov0, 0);
        chk("t4_ovf_sticky", of0, 1);
        cyc(1, 0, 0, 0);
        chk("t4_clear_ovf", of0, 0);

        // 5: push coinciding with pop while full
        for (int i = 0; i < 16; i++) cyc(0, 1, 8, 0);
        cyc(0, 0, 0, 0);
        feed4(4, 4, 4, 4, 0);
        cyc(0, 0, 0, 1);
        chk("t5_level", lv0, 4);
        chk("t5_ovf", of0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
        chk("t5_drained", lv0, 0);

        // 6: async reset mid-group, then clear mid-group
        cyc(0, 1, 5, 1);
        cyc(0, 1, 5, 1);
        #2;
        reset = 0;
        model_reset();
        #1;
        check_all();
        #1;
        reset = 1;
        feed4(1, 2, 3, 4, 0);
        cyc(0, 0, 0, 0);
        chk("t6_rst_data", od0, 3);
        chk("t6_rst_level", lv0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 5, 1);
        cyc(0, 1, 5, 1);
        cyc(1, 1, 5, 1);
        feed4(1, 2, 3, 4, 0);
        cyc(0, 0, 0, 0);
        chk("t6_clr_data", od0, 3);
        chk("t6_clr_level", lv0, 1);
        cyc(0, 0, 0, 1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            c = $urandom_range(0, 59) == 0;
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 2) != 0;
            rs = 16'($urandom);
            x = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 32767 : -32768) : int'(rs);
            cyc(c, v, x, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
